seg_sequence_decoder: RTL and testbench
=======================================

SEG_SEQUENCE_DECODER -- requirements
Module: seg_sequence_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples needed to accept a pattern (legal range 2..255).
REQ-002 Parameter MAX_DIGIT, default 9: highest digit in the counting sequence; MAX_DIGIT wraps to 0 (legal range 1..9).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 seg  input  7  active-low segment bus, seg[0]=a .. seg[6]=g, synchronous to clk.
REQ-006 digit  output  4  last accepted decoded digit.
REQ-007 valid  output  1  last accepted pattern is a legal digit 0..MAX_DIGIT.
REQ-008 invalid  output  1  last accepted pattern is neither a legal digit nor blank.
REQ-009 upd  output  1  one-cycle pulse on every pattern acceptance.
REQ-010 seq_err  output  1  one-cycle pulse when the sequence rule is violated.
REQ-011 fault  output  1  sticky, high while the FSM is in FAULT.
REQ-012 step_count  output  8  count of correct sequence steps, saturating at 255.

Function
REQ-013 Digit table (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-014 seg shall be registered once before any comparison.
REQ-015 A pattern shall be accepted when sampled identically on STABLE_CYCLES consecutive edges and it differs from the currently accepted pattern.
REQ-016 Any sample differing from the previous sample shall restart the stability count at 1.
REQ-017 A held pattern shall be accepted only once; re-acceptance requires an intervening different accepted pattern.
REQ-018 Outputs shall update on the edge after the STABLE_CYCLES-th identical sample, giving latency STABLE_CYCLES+1 edges from the first sample.
REQ-019 On acceptance: upd=1 for one cycle.
REQ-020 On acceptance of a legal digit d <= MAX_DIGIT: digit=d, valid=1, invalid=0.
REQ-021 On acceptance of blank: valid=0, invalid=0, digit unchanged.
REQ-022 On acceptance of any other pattern, including digits above MAX_DIGIT: valid=0, invalid=1, digit unchanged.
REQ-023 FSM states: IDLE, TRACK, FAULT; the FSM changes only on acceptance edges.
REQ-024 IDLE: legal digit -> TRACK and last=d; blank or invalid pattern -> stay in IDLE.
REQ-025 TRACK, legal d equal to expected (last+1, or 0 when last=MAX_DIGIT): step_count+1 (saturating), last=d, stay in TRACK.
REQ-026 TRACK, legal d not equal to expected: seq_err pulse, -> FAULT.
REQ-027 TRACK, invalid pattern: seq_err pulse, -> FAULT.
REQ-028 TRACK, blank: -> IDLE, no error.
REQ-029 FAULT: only an accepted blank exits, -> IDLE; digits and invalid patterns are decoded per REQ-019..REQ-022 but raise no further seq_err.
REQ-030 fault=1 exactly while the state is FAULT.
REQ-031 step_count shall never wrap and shall be cleared only by reset.
REQ-032 seq_err and upd in the same cycle are legal; seq_err shall never occur without upd.

Reset
REQ-033 On rst=1, immediately and asynchronously: digit=0, valid=0, invalid=0, upd=0, seq_err=0, fault=0, step_count=0, state=IDLE.
REQ-034 On rst=1, the accepted pattern shall become blank and the stability count shall clear.
REQ-035 Reset asserted mid-stabilization shall discard the partial count; after release a pattern needs a full STABLE_CYCLES samples to be accepted.
REQ-036 A steady blank bus after reset shall produce no upd.

Verification (STABLE_CYCLES=4, MAX_DIGIT=4)
REQ-037 Hold 1000000 after reset -> upd exactly once, on the 5th edge; digit=0, valid=1, state TRACK.
REQ-038 Apply 0,1,2,3,4,0 each held 10 cycles -> six upd pulses, step_count=5, no seq_err, fault=0.
REQ-039 Apply 0 then glitch 1111001 for 3 cycles, then back to 0 -> no upd after the first; digit stays 0.
REQ-040 Apply 0 then 2 -> seq_err pulse coincident with upd, fault=1; then 3 -> no seq_err, fault stays 1; then blank -> fault=0, state IDLE.
REQ-041 Apply 0010010 (digit 5) -> invalid=1, valid=0, seq_err if in TRACK.
REQ-042 Force step_count to 255 via long wrap sequence -> step_count stays 255; rst pulse during a 2-cycle-old pattern -> all outputs 0, pattern accepted 5 edges after release.

Source files
------------

// File: rtl/seg_sequence_decoder.sv
// Seven-segment sequence decoder: debounces an active-low segment bus and decodes digits.
// It also checks that accepted digits follow the counting order 0..MAX_DIGIT, wrapping to 0.
module seg_sequence_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_DIGIT     = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid,
  output logic       invalid,
  output logic       upd,
  output logic       seq_err,
  output logic       fault,
  output logic [7:0] step_count
);

  localparam logic [6:0] BLANK    = 7'b1111111;
  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);
  localparam logic [3:0] MAX_D    = 4'(MAX_DIGIT);
  localparam logic [3:0] NO_DIGIT = 4'hF;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return NO_DIGIT;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0: input register; vld_p0 marks that seg_p0 holds a post-reset sample
  logic [6:0] seg_p0;
  logic [6:0] seg_p1;
  logic       vld_p0;

  always_ff @(posedge clk) begin
    seg_p0 <= seg;
    seg_p1 <= seg_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= 1'b1;
  end

  // Stage p1: stability count and acceptance
  logic [7:0] cnt_p1;
  logic [7:0] cnt_nxt;
  logic [6:0] acc_p1;
  logic       same_p0;
  logic       accept;

  always_comb begin
    same_p0 = (cnt_p1 != 8'd0) && (seg_p0 == seg_p1);
    cnt_nxt = 8'd0;
    if (vld_p0) begin
      if (!same_p0)                cnt_nxt = 8'd1;
      else if (cnt_p1 == STABLE_N) cnt_nxt = cnt_p1;
      else                         cnt_nxt = cnt_p1 + 8'd1;
    end
    accept = vld_p0 && (cnt_nxt == STABLE_N) && (seg_p0 != acc_p1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= 8'd0;
      acc_p1 <= BLANK;
    end else begin
      cnt_p1 <= cnt_nxt;
      if (accept) acc_p1 <= seg_p0;
    end
  end

  // Stage p2: decode, sequence FSM and registered outputs
  state_t     state, state_n;
  logic [3:0] last, last_n;
  logic [3:0] dec_d;
  logic [3:0] exp_d;
  logic       is_blank;
  logic       is_legal;
  logic       err_n;
  logic [7:0] step_n;

  always_comb begin
    dec_d    = seg_decode(seg_p0);
    is_blank = (seg_p0 == BLANK);
    is_legal = (dec_d != NO_DIGIT) && (dec_d <= MAX_D);
    exp_d    = (last == MAX_D) ? 4'd0 : last + 4'd1;
    state_n  = state;
    last_n   = last;
    err_n    = 1'b0;
    step_n   = step_count;
    if (accept) begin
      case (state)
        IDLE: begin
          if (is_legal) begin
            state_n = TRACK;
            last_n  = dec_d;
          end
        end
        TRACK: begin
          if (is_legal && dec_d == exp_d) begin
            step_n = sat_inc(step_count);
            last_n = dec_d;
          end else if (is_blank) begin
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = FAULT;
          end
        end
        FAULT: begin
          if (is_blank) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 4'd0;
      digit      <= 4'd0;
      valid      <= 1'b0;
      invalid    <= 1'b0;
      upd        <= 1'b0;
      seq_err    <= 1'b0;
      step_count <= 8'd0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      upd        <= accept;
      seq_err    <= err_n;
      step_count <= step_n;
      if (accept) begin
        if (is_legal) begin
          digit   <= dec_d;
          valid   <= 1'b1;
          invalid <= 1'b0;
        end else if (is_blank) begin
          valid   <= 1'b0;
          invalid <= 1'b0;
        end else begin
          valid   <= 1'b0;
          invalid <= 1'b1;
        end
      end
    end
  end

  assign fault = (state == FAULT);

endmodule

// File: tb/tb_seg_sequence_decoder.sv
// Scoreboard bench for seg_sequence_decoder (STABLE_CYCLES=4, MAX_DIGIT=4).
// Stimulus queues the expected result of each acceptance; a negedge monitor checks every upd.
module tb_seg_sequence_decoder;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] JUNK = 7'b0101010;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] digit;
  logic       valid, invalid, upd, seq_err, fault;
  logic [7:0] step_count;

  seg_sequence_decoder #(.STABLE_CYCLES(4), .MAX_DIGIT(4)) dut (
    .clk(clk), .rst(rst), .seg(seg), .digit(digit), .valid(valid), .invalid(invalid),
    .upd(upd), .seq_err(seq_err), .fault(fault), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  d;
    logic        v;
    logic        i;
    logic        e;
    logic        f;
    logic [7:0]  sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t x;
    exp_t got;
    if (!rst) begin
      checks++;
      if (seq_err && !upd) begin
        errors++;
        $display("FAIL seq_err_without_upd cyc=%0d seq_err=%b upd=%b", cyc, seq_err, upd);
      end
      if (upd) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_upd cyc=%0d digit=%0d valid=%b invalid=%b", cyc, digit, valid, invalid);
        end else begin
          x   = q.pop_front();
          got = '{32'(cyc), digit, valid, invalid, seq_err, fault, step_count};
          if (got != x) begin
            errors++;
            $display("FAIL upd_event cyc got=%0d exp=%0d digit %0d/%0d valid %b/%b invalid %b/%b seq_err %b/%b fault %b/%b step %0d/%0d (got/exp)",
                     got.cyc, x.cyc, got.d, x.d, got.v, x.v, got.i, x.i, got.e, x.e, got.f, x.f, got.sc, x.sc);
          end
        end
      end
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input logic [6:0] p, input int n, input logic [3:0] d, input logic v,
                       input logic i, input logic e, input logic f, input logic [7:0] sc);
    q.push_back('{32'(cyc + 5), d, v, i, e, f, sc});
    hold(p, n);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({digit, valid, invalid, upd, seq_err, fault, step_count} != 19'd0) begin
      errors++;
      $display("FAIL %s digit=%0d valid=%b invalid=%b upd=%b seq_err=%b fault=%b step=%0d required all zero",
               name, digit, valid, invalid, upd, seq_err, fault, step_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    seg = BL;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    hold(BL, 10);

    // Counting sequence 0..4 and wrap to 0
    apply(S0, 10, 4'd0, 1, 0, 0, 0, 8'd0);
    apply(S1, 10, 4'd1, 1, 0, 0, 0, 8'd1);
    apply(S2, 10, 4'd2, 1, 0, 0, 0, 8'd2);
    apply(S3, 10, 4'd3, 1, 0, 0, 0, 8'd3);
    apply(S4, 10, 4'd4, 1, 0, 0, 0, 8'd4);
    apply(S0, 10, 4'd0, 1, 0, 0, 0, 8'd5);

    // Short glitch then return to the accepted pattern
    hold(S1, 3);
    hold(S0, 10);
    checks++;
    if (digit != 4'd0 || valid != 1'b1) begin
      errors++;
      $display("FAIL glitch_digit digit=%0d valid=%b required digit=0 valid=1", digit, valid);
    end

    // Out-of-order digit, then digits inside FAULT, then blank exit
    apply(S2, 10, 4'd2, 1, 0, 1, 1, 8'd5);
    apply(S3, 10, 4'd3, 1, 0, 0, 1, 8'd5);
    apply(BL, 10, 4'd3, 0, 0, 0, 0, 8'd5);

    // Digit above MAX_DIGIT in TRACK and in IDLE, junk pattern, resume tracking
    apply(S0, 10, 4'd0, 1, 0, 0, 0, 8'd5);
    apply(S5, 10, 4'd0, 0, 1, 1, 1, 8'd5);
    apply(BL, 10, 4'd0, 0, 0, 0, 0, 8'd5);
    apply(S5, 10, 4'd0, 0, 1, 0, 0, 8'd5);
    apply(JUNK, 10, 4'd0, 0, 1, 0, 0, 8'd5);
    apply(S3, 10, 4'd3, 1, 0, 0, 0, 8'd5);
    apply(S4, 10, 4'd4, 1, 0, 0, 0, 8'd6);
    apply(BL, 10, 4'd4, 0, 0, 0, 0, 8'd6);

    // Long wrapping sequence drives step_count into saturation
    apply(S0, 5, 4'd0, 1, 0, 0, 0, 8'd6);
    for (int k = 1; k <= 252; k++) begin
      logic [6:0] tab [5];
      tab = '{S0, S1, S2, S3, S4};
      apply(tab[k % 5], 5, 4'(k % 5), 1, 0, 0, 0, 8'((6 + k > 255) ? 255 : 6 + k));
    end

    // Reset in the middle of stabilizing a new pattern
    hold(S1, 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_mid_pattern");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    apply(S1, 10, 4'd1, 1, 0, 0, 0, 8'd0);

    repeat (10) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_upd pending=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
